// File: rtl/addr_seq_ctrl_if.sv
// rtl/addr_seq_ctrl_if.sv - requester, address-generator and address-stream bundle
interface addr_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_base;
  logic [ADDR_WIDTH-1:0] req0_stride;
  logic [CNT_WIDTH-1:0]  req0_count;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_base;
  logic [ADDR_WIDTH-1:0] req1_stride;
  logic [CNT_WIDTH-1:0]  req1_count;

  logic                  ag_en;
  logic                  ag_load_base;
  logic [ADDR_WIDTH-1:0] ag_base_addr;
  logic [ADDR_WIDTH-1:0] ag_stride;
  logic [ADDR_WIDTH-1:0] ag_addr;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_id;

  logic                  done;
  logic                  done_id;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_base, req0_stride, req0_count,
    input  req1_valid, req1_base, req1_stride, req1_count,
    input  ag_addr, out_ready,
    output req0_ready, req1_ready,
    output ag_en, ag_load_base, ag_base_addr, ag_stride,
    output out_valid, out_addr, out_id,
    output done, done_id, busy
  );

  modport master (
    output req0_valid, req0_base, req0_stride, req0_count,
    output req1_valid, req1_base, req1_stride, req1_count,
    output ag_addr, out_ready,
    input  req0_ready, req1_ready,
    input  ag_en, ag_load_base, ag_base_addr, ag_stride,
    input  out_valid, out_addr, out_id,
    input  done, done_id, busy
  );
endinterface

// File: rtl/addr_seq_ctrl.sv
// rtl/addr_seq_ctrl.sv - two-requester round-robin burst sequencer driving an external address generator
module addr_seq_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input logic            clk,
  input logic            reset,
  addr_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic                  id_q;
  logic                  last_grant_q;
  logic                  done_q;
  logic                  done_id_q;

  logic                  grant_valid;
  logic                  grant_id;
  logic [ADDR_WIDTH-1:0] grant_base;
  logic [ADDR_WIDTH-1:0] grant_stride;
  logic [CNT_WIDTH-1:0]  grant_count;
  logic                  accept;
  logic                  fire;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_id = ~last_grant_q;
    else                                  grant_id = bus.req1_valid;
    grant_base   = grant_id ? bus.req1_base   : bus.req0_base;
    grant_stride = grant_id ? bus.req1_stride : bus.req0_stride;
    grant_count  = grant_id ? bus.req1_count  : bus.req0_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.req0_ready   = 1'b0;
    bus.req1_ready   = 1'b0;
    bus.ag_en        = 1'b0;
    bus.ag_load_base = 1'b0;
    bus.out_valid    = 1'b0;
    bus.out_addr     = '0;
    bus.out_id       = 1'b0;
    accept           = 1'b0;
    fire             = 1'b0;
    case (state)
      IDLE: begin
        bus.req0_ready = grant_valid & ~grant_id;
        bus.req1_ready = grant_valid &  grant_id;
        accept         = grant_valid;
        if (accept && grant_count != '0) state_nxt = LOAD;
      end
      LOAD: begin
        bus.ag_load_base = 1'b1;
        bus.ag_en        = 1'b1;
        state_nxt        = RUN;
      end
      RUN: begin
        bus.out_valid = 1'b1;
        bus.out_addr  = bus.ag_addr;
        bus.out_id    = id_q;
        fire          = bus.out_ready;
        // The generator only advances when another address is still owed.
        if (fire) begin
          if (remaining_q > CNT_WIDTH'(1)) bus.ag_en = 1'b1;
          else                             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q       <= '0;
      stride_q     <= '0;
      remaining_q  <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        base_q       <= grant_base;
        stride_q     <= grant_stride;
        remaining_q  <= grant_count;
        id_q         <= grant_id;
        last_grant_q <= grant_id;
        if (grant_count == '0) begin
          done_q    <= 1'b1;
          done_id_q <= grant_id;
        end
      end
      if (fire) begin
        remaining_q <= remaining_q - CNT_WIDTH'(1);
        if (remaining_q <= CNT_WIDTH'(1)) begin
          done_q    <= 1'b1;
          done_id_q <= id_q;
        end
      end
    end
  end

  assign bus.ag_base_addr = base_q;
  assign bus.ag_stride    = stride_q;
  assign bus.done         = done_q;
  assign bus.done_id      = done_id_q;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_addr_seq_ctrl.sv
// tb/tb_addr_seq_ctrl.sv - randomized and directed checks of addr_seq_ctrl against a burst-level model
module tb_addr_seq_ctrl;
  localparam int AW = 8;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  addr_seq_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  addr_seq_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Address generator register as seen by the sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          bus.ag_addr <= '0;
    else if (bus.ag_en)  bus.ag_addr <= bus.ag_load_base ? bus.ag_base_addr : bus.ag_addr + bus.ag_stride;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic          rst_n = 1'b0;
  logic          d_valid [2];
  logic [AW-1:0] d_base  [2];
  logic [AW-1:0] d_stride[2];
  logic [CW-1:0] d_count [2];
  logic          d_ordy;
  bit            keep_valid = 0;
  bit            pend[2];

  // Burst-level model: active burst emits base + k*stride for k = 0..count-1.
  bit            m_active, m_first, m_done, m_done_id, m_last, m_id;
  logic [AW-1:0] m_base, m_stride;
  int            m_cnt, m_k;

  int            fire_cyc[$];
  logic [AW-1:0] fire_addr[$];
  bit            fire_id[$];
  int            done_cyc[$];
  bit            done_idq[$];
  int            acc_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_first = 0; m_done = 0; m_done_id = 0;
    m_last = 1; m_id = 0; m_base = '0; m_stride = '0; m_cnt = 0; m_k = 0;
  endtask

  task automatic clear_logs();
    fire_cyc.delete(); fire_addr.delete(); fire_id.delete();
    done_cyc.delete(); done_idq.delete(); acc_cyc.delete();
  endtask

  task automatic step();
    bit any, gid, e_ov, e_fire, e_agen;
    logic [AW-1:0] ea;
    @(negedge clk);
    reset          = rst_n;
    bus.req0_valid = d_valid[0]; bus.req0_base = d_base[0]; bus.req0_stride = d_stride[0]; bus.req0_count = d_count[0];
    bus.req1_valid = d_valid[1]; bus.req1_base = d_base[1]; bus.req1_stride = d_stride[1]; bus.req1_count = d_count[1];
    bus.out_ready  = d_ordy;
    if (!rst_n) model_reset();
    #1;
    any    = !m_active && (d_valid[0] || d_valid[1]);
    gid    = (d_valid[0] && d_valid[1]) ? !m_last : d_valid[1];
    e_ov   = m_active && !m_first;
    e_fire = e_ov && d_ordy;
    e_agen = (m_active && m_first) || (e_fire && (m_k + 1 < m_cnt));
    ea     = m_base + AW'(m_k) * m_stride;
    chk("req0_ready", bus.req0_ready, any && !gid);
    chk("req1_ready", bus.req1_ready, any && gid);
    chk("busy", bus.busy, m_active);
    chk("ag_load_base", bus.ag_load_base, m_active && m_first);
    chk("ag_en", bus.ag_en, e_agen);
    chk("ag_stride", bus.ag_stride, m_stride);
    chk("out_valid", bus.out_valid, e_ov);
    chk("done", bus.done, m_done);
    if (m_first) chk("ag_base_addr", bus.ag_base_addr, m_base);
    if (e_ov) begin
      chk("out_addr", bus.out_addr, ea);
      chk("out_id", bus.out_id, m_id);
    end
    if (m_done) chk("done_id", bus.done_id, m_done_id);

    if (bus.out_valid && bus.out_ready) begin
      fire_cyc.push_back(cyc); fire_addr.push_back(bus.out_addr); fire_id.push_back(bus.out_id);
    end
    if (bus.done) begin
      done_cyc.push_back(cyc); done_idq.push_back(bus.done_id);
    end
    if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) acc_cyc.push_back(cyc);

    if (rst_n) begin
      m_done = 0;
      if (!m_active) begin
        if (any) begin
          m_last = gid; m_id = gid;
          m_base = d_base[gid]; m_stride = d_stride[gid];
          if (d_count[gid] == 0) begin
            m_done = 1; m_done_id = gid;
          end else begin
            m_active = 1; m_first = 1; m_k = 0; m_cnt = int'(d_count[gid]);
          end
          pend[gid] = 0;
          if (!keep_valid) d_valid[gid] = 0;
        end
      end else if (m_first) begin
        m_first = 0;
      end else if (d_ordy) begin
        if (m_k + 1 >= m_cnt) begin
          m_active = 0; m_done = 1; m_done_id = m_id;
        end else begin
          m_k++;
        end
      end
    end
    cyc++;
  endtask

  task automatic issue(input int r, input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] n);
    d_valid[r] = 1; d_base[r] = b; d_stride[r] = s; d_count[r] = n;
  endtask

  task automatic do_reset();
    rst_n = 0; step(); step(); rst_n = 1;
  endtask

  int c0;

  initial begin
    model_reset();
    for (int r = 0; r < 2; r++) begin
      d_valid[r] = 0; d_base[r] = '0; d_stride[r] = '0; d_count[r] = '0; pend[r] = 0;
    end
    d_ordy = 1;

    rst_n = 0;
    step();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ag_en", bus.ag_en, 1'b0);
    step();
    rst_n = 1;

    // basic burst
    clear_logs(); c0 = cyc;
    issue(0, 8'h10, 8'h04, 8'd3);
    repeat (7) step();
    chk("b_acc_n", acc_cyc.size(), 1);
    chk("b_fire_n", fire_addr.size(), 3);
    if (fire_addr.size() == 3) begin
      chk("b_a0", fire_addr[0], 8'h10); chk("b_a1", fire_addr[1], 8'h14); chk("b_a2", fire_addr[2], 8'h18);
      chk("b_c0", fire_cyc[0], c0 + 2); chk("b_c2", fire_cyc[2], c0 + 4);
    end
    chk("b_done_n", done_cyc.size(), 1);
    if (done_cyc.size() == 1) begin
      chk("b_done_c", done_cyc[0], c0 + 5); chk("b_done_id", done_idq[0], 1'b0);
    end

    // alternation with both requesters valid
    do_reset();
    clear_logs(); keep_valid = 1;
    issue(0, 8'h20, 8'h01, 8'd1);
    issue(1, 8'h40, 8'h01, 8'd1);
    repeat (12) step();
    keep_valid = 0; d_valid[0] = 0; d_valid[1] = 0;
    repeat (3) step();
    chk("alt_n", fire_id.size(), 4);
    if (fire_id.size() == 4) begin
      chk("alt_id0", fire_id[0], 1'b0); chk("alt_id1", fire_id[1], 1'b1);
      chk("alt_id2", fire_id[2], 1'b0); chk("alt_id3", fire_id[3], 1'b1);
      chk("alt_a1", fire_addr[1], 8'h40); chk("alt_a2", fire_addr[2], 8'h20);
    end

    // wrap
    clear_logs();
    issue(0, 8'hF8, 8'h10, 8'd3);
    repeat (7) step();
    chk("wrap_n", fire_addr.size(), 3);
    if (fire_addr.size() == 3) begin
      chk("wrap_a0", fire_addr[0], 8'hF8); chk("wrap_a1", fire_addr[1], 8'h08); chk("wrap_a2", fire_addr[2], 8'h18);
    end

    // stall on the second address
    clear_logs();
    issue(0, 8'h10, 8'h04, 8'd3);
    step(); step(); step();
    d_ordy = 0;
    step();
    chk("stall_addr0", bus.out_addr, 8'h14); chk("stall_en0", bus.ag_en, 1'b0); chk("stall_v0", bus.out_valid, 1'b1);
    step();
    chk("stall_addr1", bus.out_addr, 8'h14); chk("stall_en1", bus.ag_en, 1'b0);
    d_ordy = 1;
    repeat (4) step();
    chk("stall_n", fire_addr.size(), 3);
    if (fire_addr.size() == 3) begin
      chk("stall_a0", fire_addr[0], 8'h10); chk("stall_a1", fire_addr[1], 8'h14); chk("stall_a2", fire_addr[2], 8'h18);
    end

    // zero-count command
    clear_logs(); c0 = cyc;
    issue(1, 8'h33, 8'h01, 8'd0);
    step();
    chk("z_busy0", bus.busy, 1'b0);
    step();
    chk("z_busy1", bus.busy, 1'b0);
    step();
    chk("z_fire_n", fire_addr.size(), 0);
    chk("z_done_n", done_cyc.size(), 1);
    if (done_cyc.size() == 1) begin
      chk("z_done_c", done_cyc[0], c0 + 1); chk("z_done_id", done_idq[0], 1'b1);
    end

    // reset mid-burst, then a fresh command
    clear_logs();
    issue(0, 8'h10, 8'h04, 8'd3);
    step(); step(); step();
    rst_n = 0;
    step();
    chk("mr_out_valid", bus.out_valid, 1'b0); chk("mr_ag_en", bus.ag_en, 1'b0);
    chk("mr_load", bus.ag_load_base, 1'b0); chk("mr_done", bus.done, 1'b0);
    chk("mr_busy", bus.busy, 1'b0); chk("mr_stride", bus.ag_stride, 8'h00);
    step();
    rst_n = 1;
    issue(1, 8'h50, 8'h02, 8'd2);
    repeat (6) step();
    chk("mr_fire_n", fire_addr.size(), 3);
    if (fire_addr.size() == 3) begin
      chk("mr_a1", fire_addr[1], 8'h50); chk("mr_a2", fire_addr[2], 8'h52);
    end
    chk("mr_done_n", done_cyc.size(), 1);
    if (done_cyc.size() == 1) chk("mr_done_id", done_idq[0], 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom % 4 == 0)) begin
          pend[r] = 1;
          d_base[r] = AW'($urandom); d_stride[r] = AW'($urandom); d_count[r] = CW'($urandom_range(0, 4));
        end
        d_valid[r] = pend[r] && ($urandom % 4 != 0);
      end
      d_ordy = ($urandom % 10) < 7;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addr_seq_ctrl.md
ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8, width of base, stride and address.
REQ-002 Parameter: CNT_WIDTH, default 8, width of burst count.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) command valid.
REQ-006 reqN_ready  output  1  requester N command accepted when valid&ready.
REQ-007 reqN_base, reqN_stride  input  ADDR_WIDTH  requester N start address and stride.
REQ-008 reqN_count  input  CNT_WIDTH  requester N number of addresses to emit.
REQ-009 ag_en, ag_load_base  output  1  enable and load-base controls to the address generator.
REQ-010 ag_base_addr, ag_stride  output  ADDR_WIDTH  base and stride to the address generator.
REQ-011 ag_addr  input  ADDR_WIDTH  address generator register value.
REQ-012 out_valid  output  1; out_ready  input  1  address stream handshake.
REQ-013 out_addr  output  ADDR_WIDTH; out_id  output  1  emitted address and owning requester.
REQ-014 done  output  1; done_id  output  1  one-cycle burst-complete pulse and its requester.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN.
REQ-017 In IDLE, round-robin arbitration SHALL grant one valid requester; the requester not granted last SHALL win a tie; reqN_ready SHALL be combinational, high only for the granted requester in IDLE.
REQ-018 On accept, block SHALL capture base, stride, count (into remaining) and id.
REQ-019 Accepted count of 0 SHALL emit no address, stay in IDLE, and pulse done/done_id on the next cycle.
REQ-020 Accepted count >0 SHALL move to LOAD on the next edge.
REQ-021 In LOAD, ag_load_base=1, ag_en=1, ag_base_addr=captured base for exactly one cycle; next state RUN.
REQ-022 ag_stride SHALL equal captured stride at all times; ag_load_base SHALL be 0 outside LOAD.
REQ-023 In RUN, out_valid=1, out_addr=ag_addr, out_id=captured id; first out_valid SHALL occur 2 cycles after the accept edge.
REQ-024 In RUN, on out_valid&out_ready with remaining>1: ag_en=1 that cycle, remaining decrements; out_addr, out_valid hold stable while out_ready=0.
REQ-025 On the fire with remaining==1: ag_en=0, next state IDLE, done=1 and done_id=id on the following cycle.
REQ-026 Throughput SHALL be one address per cycle with out_ready held high.
REQ-027 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no overflow flag.
REQ-028 A new command SHALL be acceptable in the same cycle done is high.
REQ-029 reqN_valid deasserting without acceptance SHALL have no effect; no command SHALL be accepted outside IDLE.

Reset
REQ-030 On reset low: state IDLE; out_valid, ag_en, ag_load_base, done, busy, reqN_ready (via state) = 0; captured base, stride, remaining, id, done_id = 0; last-grant = 1 so requester 0 wins first.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no done pulse.

Verification
REQ-032 req0 base=0x10 stride=4 count=3, out_ready=1 -> out_addr 0x10,0x14,0x18 on consecutive cycles, first 2 cycles after accept, done/done_id=0 one cycle after last.
REQ-033 Both requesters valid continuously, count=1 each -> grants alternate 0,1,0,1; out_id matches.
REQ-034 base=0xF8 stride=0x10 count=3 -> 0xF8,0x08,0x18 (wrap).
REQ-035 count=3, out_ready low 2 cycles on second address -> 0x14 held stable, ag_en=0 while stalled, sequence unchanged.
REQ-036 count=0 -> no out_valid, done pulse next cycle, busy stays 0.
REQ-037 reset low during RUN after first address -> all outputs 0 next, no done; new command after release runs normally from IDLE.
